// File: rtl/bnn_conv3x3.sv
// rtl/bnn_conv3x3.sv - binary 3x3 XNOR-popcount convolution sweep with valid/ready result stream
module bnn_conv3x3 #(
    parameter int IMG    = 28,
    parameter int NF     = 8,
    parameter int THRESH = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [IMG*IMG-1:0]  pixels_flat,
    input  logic [NF*9-1:0]     weights_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic [3:0]          out_match,
    output logic [2:0]          out_f,
    output logic [4:0]          out_r,
    output logic [4:0]          out_c,
    output logic                busy,
    output logic                done
);
    localparam int PW = $clog2(IMG*IMG);
    localparam int WW = $clog2(NF*9);
    localparam logic [4:0] LAST_RC = 5'(IMG-3);
    localparam logic [2:0] LAST_F  = 3'(NF-1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic [2:0]  fi;
    logic [4:0]  ri, ci;
    logic [8:0]  win, wgt;
    logic [3:0]  mism, match;
    logic        res_bit;
    logic        ld, last_pos;
    int          p;

    // Window and filter are picked straight from the frozen loader buses by the current indices.
    always_comb begin
        win  = '0;
        mism = '0;
        p    = 0;
        wgt  = weights_flat[WW'(32'(fi) * 9) +: 9];
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                p = (int'(ri) + kr) * IMG + int'(ci) + kc;
                win[4'(kr*3 + kc)] = pixels_flat[PW'(p)];
            end
        end
        for (int k = 0; k < 9; k++) begin
            mism = mism + 4'(win[4'(k)] ^ wgt[4'(k)]);
        end
        match   = 4'd9 - mism;
        res_bit = (match >= 4'(THRESH));
    end

    assign ld       = (state == S_RUN) && (!out_valid || out_ready);
    assign last_pos = (fi == LAST_F) && (ri == LAST_RC) && (ci == LAST_RC);
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            fi        <= '0;
            ri        <= '0;
            ci        <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_match <= '0;
            out_f     <= '0;
            out_r     <= '0;
            out_c     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_RUN;
                S_RUN: begin
                    if (ld) begin
                        out_valid <= 1'b1;
                        out_bit   <= res_bit;
                        out_match <= match;
                        out_f     <= fi;
                        out_r     <= ri;
                        out_c     <= ci;
                        // Indices park on the last position; they clear on the way back to IDLE.
                        if (last_pos) begin
                            state <= S_DRAIN;
                        end else if (ci == LAST_RC) begin
                            ci <= '0;
                            if (ri == LAST_RC) begin
                                ri <= '0;
                                fi <= fi + 3'd1;
                            end else begin
                                ri <= ri + 5'd1;
                            end
                        end else begin
                            ci <= ci + 5'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                        fi    <= '0;
                        ri    <= '0;
                        ci    <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_conv3x3.sv
// tb/tb_bnn_conv3x3.sv - scoreboard bench for bnn_conv3x3
module tb_bnn_conv3x3;
    localparam int IMG  = 28;
    localparam int NF   = 8;
    localparam int NPOS = (IMG-2)*(IMG-2);

    logic                clk = 1'b0;
    logic                reset_n, start, out_ready;
    logic [IMG*IMG-1:0]  pixels_flat;
    logic [NF*9-1:0]     weights_flat;
    logic                out_valid, out_bit, busy, done;
    logic [3:0]          out_match;
    logic [2:0]          out_f;
    logic [4:0]          out_r, out_c;
    logic                out_valid9, out_bit9, busy9, done9;
    logic [3:0]          out_match9;
    logic [2:0]          out_f9;
    logic [4:0]          out_r9, out_c9;

    always #5 clk = ~clk;

    bnn_conv3x3 #(.IMG(IMG), .NF(NF), .THRESH(5)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .pixels_flat(pixels_flat), .weights_flat(weights_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_match(out_match), .out_f(out_f), .out_r(out_r), .out_c(out_c),
        .busy(busy), .done(done)
    );

    bnn_conv3x3 #(.IMG(IMG), .NF(NF), .THRESH(9)) u_dut9 (
        .clk(clk), .reset_n(reset_n), .start(start),
        .pixels_flat(pixels_flat), .weights_flat(weights_flat),
        .out_valid(out_valid9), .out_ready(out_ready), .out_bit(out_bit9),
        .out_match(out_match9), .out_f(out_f9), .out_r(out_r9), .out_c(out_c9),
        .busy(busy9), .done(done9)
    );

    typedef struct packed {
        logic       b;
        logic       b9;
        logic [3:0] m;
        logic [2:0] f;
        logic [4:0] r;
        logic [4:0] c;
    } exp_t;

    exp_t        sbq[$];
    logic [8:0]  w [NF];
    bit          has_px;
    int          pr, pc;
    int          checks = 0, failures = 0;
    int          ready_mode = 0;
    int          hs_count = 0;
    int          zero9 = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected match for an image with at most one set pixel.
    function automatic int exp_match(int f, int r, int c);
        int mm = $countones(w[f]);
        if (has_px && pr >= r && pr <= r+2 && pc >= c && pc <= c+2)
            mm += w[f][(pr-r)*3 + (pc-c)] ? -1 : 1;
        return 9 - mm;
    endfunction

    task automatic load_pattern();
        pixels_flat = '0;
        if (has_px) pixels_flat[pr*IMG + pc] = 1'b1;
        for (int f = 0; f < NF; f++) weights_flat[f*9 +: 9] = w[f];
    endtask

    task automatic push_frame();
        exp_t e;
        int m;
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < IMG-2; r++)
                for (int c = 0; c < IMG-2; c++) begin
                    m    = exp_match(f, r, c);
                    e.b  = (m >= 5);
                    e.b9 = (m >= 9);
                    e.m  = 4'(m);
                    e.f  = 3'(f);
                    e.r  = 5'(r);
                    e.c  = 5'(c);
                    sbq.push_back(e);
                end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
        check("sb_empty", sbq.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) out_ready = ($urandom_range(3) != 0);
        end
    end

    // Monitor: pops expected results on every handshake and checks hold during stalls.
    initial begin
        exp_t  e;
        logic  [18:0] got, held;
        bit    stall_prev = 0, chk_done = 0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {out_bit, out_bit9, out_match, out_f, out_r, out_c};
            if (reset_n) begin
                if (chk_done) begin
                    chk_done = 0;
                    check("done_after_last", {done, out_valid, busy}, 3'b100);
                end
                if (stall_prev && out_valid) check("stall_hold", got, held);
                if (out_valid) check("busy_while_valid", busy, 1);
                if (out_valid && out_ready) begin
                    hs_count++;
                    if (!out_bit9) zero9++;
                    check("queue_nonempty", sbq.size() != 0, 1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check("result", got, e);
                        if (sbq.size() == 0) chk_done = 1;
                    end
                end
                stall_prev = out_valid && !out_ready;
                held       = got;
            end else begin
                stall_prev = 0;
                chk_done   = 0;
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        has_px = 0; pr = 0; pc = 0;
        for (int f = 0; f < NF; f++) w[f] = '0;
        load_pattern();
        repeat (3) @(negedge clk);
        check("reset_outputs", {out_valid, out_bit, out_match, out_f, out_r, out_c, busy, done}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // All-zero image and weights, with first-result latency
        push_frame();
        @(posedge clk); #1; start = 1'b1;
        @(negedge clk); check("lat_idle", {busy, out_valid}, 2'b00);
        @(negedge clk); check("lat_run", {busy, out_valid}, 2'b10);
        @(negedge clk); check("lat_first", {busy, out_valid, out_f, out_r, out_c}, {2'b11, 13'b0});
        wait_done(8000);

        // Level start holds DONE; a one-cycle drop retriggers an identical sweep
        repeat (10) begin
            @(negedge clk);
            check("level_start_hold", {done, out_valid, busy}, 3'b100);
        end
        start = 1'b0;
        @(negedge clk); check("back_to_idle", {done, busy, out_valid}, 3'b000);
        push_frame();
        start = 1'b1;
        wait_done(8000);
        start = 1'b0;
        @(negedge clk);

        // Single pixel at (10,10), random backpressure
        has_px = 1; pr = 10; pc = 10;
        load_pattern();
        push_frame();
        zero9 = 0;
        ready_mode = 1;
        start = 1'b1;
        wait_done(15000);
        check("thresh9_zero_bits", zero9, 9*NF);
        start = 1'b0;
        @(negedge clk);

        // Threshold boundary on filter 0: window (0,0) gives 5, window (3,3) gives 4
        has_px = 1; pr = 5; pc = 5;
        w[0] = 9'h00F;
        load_pattern();
        push_frame();
        ready_mode = 0; out_ready = 1'b0;
        start = 1'b1;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (20) begin
            @(negedge clk);
            check("hold_first", {out_valid, out_f, out_r, out_c}, {1'b1, 13'b0});
        end
        ready_mode = 1;
        wait_done(15000);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-sweep, then restart from (0,0,0)
        has_px = 0;
        w[0] = '0;
        load_pattern();
        push_frame();
        ready_mode = 0; out_ready = 1'b1;
        hs_count = 0;
        start = 1'b1;
        n = 0;
        while (hs_count < 100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_100_handshakes", hs_count >= 100, 1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", {out_valid, out_bit, out_match, out_f, out_r, out_c, busy, done}, 0);
        sbq.delete();
        @(negedge clk);
        push_frame();
        reset_n = 1'b1;
        wait_done(8000);
        start = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
